// File: rtl/instr_loader_pkg.sv
// Shared types and sizing helpers for the instruction loader.
package instr_loader_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned calc_bpw(input int unsigned data_w);
        return data_w / BYTE_W;
    endfunction

    function automatic int unsigned calc_idle_w(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

    // A single-byte word still needs a 1-bit index to stay legal.
    function automatic int unsigned calc_idx_w(input int unsigned bpw);
        return (bpw > 1) ? $clog2(bpw) : 1;
    endfunction

endpackage

// File: rtl/instr_word_packer.sv
// Packs accepted bytes into DATA_W-bit words in either byte order; flush emits
// a pending partial word with the unfilled byte lanes left at zero.
module instr_word_packer
    import instr_loader_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              flush,
    output logic              word_valid,
    output logic [DATA_W-1:0] word_data
);

    localparam int unsigned      BPW      = calc_bpw(DATA_W);
    localparam int unsigned      IDX_W    = calc_idx_w(BPW);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  slot;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] ins;
    logic [DATA_W-1:0] merged;
    logic              last_byte;

    // Each byte lands directly in its final lane, so the accumulator is
    // already zero-filled whenever a partial word has to be flushed.
    always_comb begin
        slot       = (MSB_FIRST != 0) ? (LAST_IDX - idx) : idx;
        ins        = DATA_W'(byte_data) << (BYTE_W * slot);
        merged     = acc | ins;
        last_byte  = byte_valid && (idx == LAST_IDX);
        word_valid = last_byte || (flush && (idx != '0));
        word_data  = flush ? acc : merged;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
            acc <= '0;
        end else if (clear || flush || last_byte) begin
            idx <= '0;
            acc <= '0;
        end else if (byte_valid) begin
            idx <= idx + 1'b1;
            acc <= merged;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// UART byte stream to instruction BRAM loader with idle-timeout end of load.
// Optional checksum output enabled by defining INSTR_LOADER_CHECKSUM_EN.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned IDLE_TIMEOUT = 1000,
    parameter int unsigned MSB_FIRST    = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    input  logic              i_restart,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic [ADDR_W-1:0] o_max_addr,
    output logic [ADDR_W:0]   o_word_count,
    output logic              o_busy,
    output logic              o_load_done,
    output logic              o_overflow,
    output logic [7:0]        o_checksum
);

    localparam int unsigned       IDLE_W   = calc_idle_w(IDLE_TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);
    localparam logic [ADDR_W:0]   DEPTH    = {1'b1, {ADDR_W{1'b0}}};

    state_t            state;
    state_t            state_nxt;
    logic [IDLE_W-1:0] idle_cnt;
    logic              accept;
    logic              timeout;
    logic              word_valid;
    logic [DATA_W-1:0] word_data;

    always_comb begin
        accept  = i_rx_valid && !i_restart && (state != DONE);
        timeout = (state == RECV) && !accept && !i_restart && (idle_cnt == IDLE_MAX);
    end

    always_comb begin
        state_nxt = state;
        if (i_restart) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (i_rx_valid) state_nxt = RECV;
                RECV:    if (timeout) state_nxt = DONE;
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idle_cnt <= '0;
        end else if (i_restart || accept) begin
            idle_cnt <= '0;
        end else if ((state == RECV) && (idle_cnt != IDLE_MAX)) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    instr_word_packer #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_packer (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .clear      (i_restart),
        .byte_valid (accept),
        .byte_data  (i_rx_data),
        .flush      (timeout),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    // The word count doubles as the next write address.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wr_en      <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= '0;
            o_max_addr   <= '0;
            o_word_count <= '0;
            o_overflow   <= 1'b0;
        end else begin
            o_wr_en <= 1'b0;
            if (i_restart) begin
                o_wr_addr    <= '0;
                o_wr_data    <= '0;
                o_max_addr   <= '0;
                o_word_count <= '0;
                o_overflow   <= 1'b0;
            end else if (word_valid) begin
                if (o_word_count == DEPTH) begin
                    o_overflow <= 1'b1;
                end else begin
                    o_wr_en      <= 1'b1;
                    o_wr_addr    <= o_word_count[ADDR_W-1:0];
                    o_wr_data    <= word_data;
                    o_max_addr   <= o_word_count[ADDR_W-1:0];
                    o_word_count <= o_word_count + 1'b1;
                end
            end
        end
    end

    // Status lags the state by one cycle so done follows any padded write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_busy      <= 1'b0;
            o_load_done <= 1'b0;
        end else if (i_restart) begin
            o_busy      <= 1'b0;
            o_load_done <= 1'b0;
        end else begin
            o_busy      <= (state == RECV);
            o_load_done <= (state == DONE);
        end
    end

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0] checksum;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            checksum <= '0;
        end else if (i_restart) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= checksum + i_rx_data;
        end
    end

    assign o_checksum = checksum;
`else
    assign o_checksum = '0;
`endif

endmodule
